// File: rtl/piso_serial_tx_pkg.sv
// Shared encodings for the serial link: FSM states, idle line level and counter sizing.
package piso_serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  localparam logic LINE_IDLE = 1'b1;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_serial_tx_bit_tick_counter.sv
// Bit-period divider: tick marks the last clock of each DIV-cycle bit period.
module bit_tick_counter
  import piso_serial_tx_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = count_q + 1'b1;
    if (restart || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Framed PISO transmitter: start bit, WIDTH data bits LSB-first, stop bit, DIV clocks per bit.
module piso_serial_tx
  import piso_serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             tick;
  logic             accept;
  logic             div_restart;

  assign accept      = (state_q == ST_IDLE) && load;
  // Divider is held at zero while idle so every frame starts on a fresh bit period.
  assign div_restart = (state_q == ST_IDLE);

  bit_tick_counter #(
    .DIV(DIV)
  ) u_bit_tick (
    .clk    (clk),
    .clear  (clear),
    .restart(div_restart),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA:  if (tick && (bit_cnt_q == LAST_BIT)) state_d = ST_STOP;
      ST_STOP:  if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The bit count saturates at the last bit and is only cleared on accept.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (accept) begin
      shift_d   = data_in;
      bit_cnt_d = '0;
    end else if ((state_q == ST_DATA) && tick) begin
      shift_d = shift_q >> 1;
      if (bit_cnt_q != LAST_BIT) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  always_comb begin
    ready  = 1'b0;
    busy   = 1'b1;
    done   = 1'b0;
    tx_out = LINE_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      ST_START: tx_out = 1'b0;
      ST_DATA:  tx_out = shift_q[0];
      ST_STOP:  done = tick;
      default: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: one instance at DIV=4, one at DIV=1, both WIDTH=8.
module tb_piso_serial_tx;

  logic       clk = 1'b0;
  logic       clear, load;
  logic [7:0] data_in;
  logic       ready, tx_out, busy, done;
  logic       clear1, load1;
  logic [7:0] data1;
  logic       ready1, tx1, busy1, done1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Frame bit sequences, bit i = line level in bit period i (start first).
  logic [9:0] seq_a5 = 10'b1101001010;
  logic [9:0] seq_3c = 10'b1001111000;
  logic [9:0] seq_01 = 10'b1000000010;

  always #5 clk = ~clk;

  piso_serial_tx #(.WIDTH(8), .DIV(4)) dut (
    .clk    (clk),
    .clear  (clear),
    .data_in(data_in),
    .load   (load),
    .ready  (ready),
    .tx_out (tx_out),
    .busy   (busy),
    .done   (done)
  );

  piso_serial_tx #(.WIDTH(8), .DIV(1)) dut1 (
    .clk    (clk),
    .clear  (clear1),
    .data_in(data1),
    .load   (load1),
    .ready  (ready1),
    .tx_out (tx1),
    .busy   (busy1),
    .done   (done1)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " tx"}, 32'(tx_out), 32'd1);
    check({tag, " ready"}, 32'(ready), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
  endtask

  // Called in the first cycle after the accept edge; returns in the cycle after done.
  task automatic check_frame(input string tag, input logic [9:0] seq, input bit inject,
                             output int done_at);
    done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      check($sformatf("%s tx c%0d", tag, c), 32'(tx_out), 32'(seq[(c-1)/4]));
      check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == 40));
      check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'd1);
      check($sformatf("%s ready c%0d", tag, c), 32'(ready), 32'd0);
      if (done) done_at = cyc;
      if (inject && c == 10) begin
        data_in = 8'hFF;
        load    = 1'b1;
      end
      if (inject && c == 11) load = 1'b0;
      step();
    end
  endtask

  initial begin
    int d1, d2, dx;
    clear   = 1'b1;
    load    = 1'b0;
    data_in = 8'h00;
    clear1  = 1'b1;
    load1   = 1'b0;
    data1   = 8'h00;

    // Reset and quiet idle
    step();
    step();
    check_idle("reset");
    check("reset1 ready", 32'(ready1), 32'd1);
    check("reset1 tx", 32'(tx1), 32'd1);
    clear  = 1'b0;
    clear1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle($sformatf("idle%0d", i));
    end

    // Single 0xA5 frame
    data_in = 8'hA5;
    load    = 1'b1;
    step();
    load = 1'b0;
    check_frame("a5", seq_a5, 1'b0, d1);
    check_idle("a5 after");

    // Load and data change mid-frame are ignored
    data_in = 8'hA5;
    load    = 1'b1;
    step();
    load = 1'b0;
    check_frame("ign", seq_a5, 1'b1, d1);
    check_idle("ign after");
    step();
    check_idle("ign not queued");

    // Held load gives back-to-back frames with one idle cycle
    data_in = 8'h3C;
    load    = 1'b1;
    step();
    check_frame("b2b1", seq_3c, 1'b0, d1);
    check_idle("b2b gap");
    step();
    load = 1'b0;
    check_frame("b2b2", seq_3c, 1'b0, d2);
    check("b2b done spacing", 32'(d2 - d1), 32'd41);
    check_idle("b2b after");

    // Abort with clear in cycle 17
    data_in = 8'hA5;
    load    = 1'b1;
    step();
    load = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("abort tx c%0d", c), 32'(tx_out), 32'(seq_a5[(c-1)/4]));
      step();
    end
    check("abort tx c17", 32'(tx_out), 32'(seq_a5[4]));
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_idle("abort");
    for (int i = 0; i < 40; i++) begin
      step();
      check($sformatf("abort quiet done %0d", i), 32'(done), 32'd0);
      check($sformatf("abort quiet tx %0d", i), 32'(tx_out), 32'd1);
    end
    data_in = 8'hA5;
    load    = 1'b1;
    step();
    load = 1'b0;
    check_frame("post", seq_a5, 1'b0, dx);
    check_idle("post after");

    // DIV=1 instance
    data1 = 8'h01;
    load1 = 1'b1;
    step();
    load1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("d1 tx c%0d", c), 32'(tx1), 32'(seq_01[c-1]));
      check($sformatf("d1 done c%0d", c), 32'(done1), 32'(c == 10));
      check($sformatf("d1 busy c%0d", c), 32'(busy1), 32'd1);
      step();
    end
    check("d1 ready after", 32'(ready1), 32'd1);
    check("d1 tx after", 32'(tx1), 32'd1);
    clear1 = 1'b1;
    load1  = 1'b1;
    step();
    clear1 = 1'b0;
    load1  = 1'b0;
    check("d1 clr+load ready", 32'(ready1), 32'd1);
    check("d1 clr+load busy", 32'(busy1), 32'd0);
    check("d1 clr+load tx", 32'(tx1), 32'd1);
    step();
    check("d1 clr+load stays idle", 32'(busy1), 32'd0);
    check("d1 clr+load tx2", 32'(tx1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
